// File: rtl/fifo_rd_ctrl_p_if.sv
// fifo_rd_ctrl_p_if: read-side FIFO signal bundle (consumer, write-pointer crossing, RAM port).
// Latency: none, wires only.
// Backpressure: carried by rinc/rvalid (FWFT) or rinc/rempty (pop mode) inside the bundle.
// Ports: master = environment side (drives rinc, wptr, aempty_thr, mem_rdata);
//        slave  = controller side (drives raddr, ren, rdata, rvalid, flags, rlevel, rptr, rerr).
interface fifo_rd_ctrl_p_if #(
    parameter int DATASIZE = 8,
    parameter int ADDSIZE  = 4
);
    logic                rinc;
    logic [ADDSIZE:0]    wptr;
    logic [ADDSIZE:0]    aempty_thr;
    logic [ADDSIZE-1:0]  raddr;
    logic                ren;
    logic [DATASIZE-1:0] mem_rdata;
    logic [DATASIZE-1:0] rdata;
    logic                rvalid;
    logic                rempty;
    logic                ralmost_empty;
    logic [ADDSIZE:0]    rlevel;
    logic [ADDSIZE:0]    rptr;
    logic                rerr;

    modport master (
        output rinc, wptr, aempty_thr, mem_rdata,
        input  raddr, ren, rdata, rvalid, rempty, ralmost_empty, rlevel, rptr, rerr
    );

    modport slave (
        input  rinc, wptr, aempty_thr, mem_rdata,
        output raddr, ren, rdata, rvalid, rempty, ralmost_empty, rlevel, rptr, rerr
    );
endinterface

// File: rtl/fifo_rd_ctrl_p.sv
// fifo_rd_ctrl_p: read-side controller of the dual-clock gray-pointer FIFO, entirely in rclk.
// Latency: writes seen SYNC_STAGES+1 cycles after wptr settles; rdata 1 cycle after ren (FWFT=0), head valid 2 cycles after non-empty (FWFT=1).
// Backpressure: FWFT=0 pops only while not empty; FWFT=1 holds off RAM reads while the 2-entry output buffer has no room, consumer throttles with rinc.
// Ports: rclk, rrst (synchronous, active-high); bus (slave modport):
//        in  rinc, wptr (gray, async), aempty_thr, mem_rdata
//        out raddr, ren, rdata, rvalid, rempty, ralmost_empty, rlevel, rptr (gray), rerr
// SYNC_STAGES must be 2..4; ADDSIZE must be at least 2.
module fifo_rd_ctrl_p #(
    parameter int DATASIZE    = 8,
    parameter int ADDSIZE     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FWFT        = 0
) (
    input  logic            rclk,
    input  logic            rrst,
    fifo_rd_ctrl_p_if.slave bus
);

    function automatic logic [ADDSIZE:0] bin2gray(input logic [ADDSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDSIZE:0] gray2bin(input logic [ADDSIZE:0] g);
        logic [ADDSIZE:0] b;
        b = g;
        for (int i = ADDSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // write-pointer synchroniser
    logic [ADDSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDSIZE:0] wq;
    logic [ADDSIZE:0] wbin_s;

    // read pointer and status state
    logic [ADDSIZE:0]    rbin;
    logic [ADDSIZE:0]    rptr_q;
    logic                empty_int;
    logic [ADDSIZE:0]    rlevel_q;
    logic                ralmost_q;
    logic                rerr_q;
    logic                rvalid_q;

    // FWFT output buffer: buf0 is always the head
    logic [DATASIZE-1:0] buf0;
    logic [DATASIZE-1:0] buf1;
    logic [1:0]          buf_cnt;
    logic                inflight;

    logic                pop_int;
    logic                pop_out;
    logic [2:0]          occ_after;
    logic                inflight_next;
    logic [ADDSIZE:0]    rbin_next;
    logic [ADDSIZE:0]    rgray_next;
    logic [ADDSIZE:0]    level_next;
    logic                rempty_int;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.wptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq     = sync_q[SYNC_STAGES-1];
    assign wbin_s = gray2bin(wq);

    always_comb begin
        pop_out       = 1'b0;
        occ_after     = 3'd0;
        pop_int       = 1'b0;
        inflight_next = 1'b0;
        if (FWFT != 0) begin
            pop_out = bus.rinc & (buf_cnt != 2'd0);
            // Occupancy once this cycle's returning word lands and the head is taken;
            // this is also next cycle's buf_cnt.
            occ_after     = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop_out};
            pop_int       = !rrst & !empty_int & (occ_after < 3'd2);
            inflight_next = pop_int;
        end else begin
            pop_int = !rrst & bus.rinc & !empty_int;
        end
    end

    assign rbin_next  = rbin + {{ADDSIZE{1'b0}}, pop_int};
    assign rgray_next = bin2gray(rbin_next);

    // Words still in the RAM plus, in FWFT mode, words already fetched but not consumed.
    assign level_next = (wbin_s - rbin_next)
                      + {{(ADDSIZE-1){1'b0}}, occ_after[1:0]}
                      + {{ADDSIZE{1'b0}}, inflight_next};

    assign rempty_int = (FWFT != 0) ? (buf_cnt == 2'd0) : empty_int;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin      <= '0;
            rptr_q    <= '0;
            empty_int <= 1'b1;
            rlevel_q  <= '0;
            ralmost_q <= 1'b1;
            rerr_q    <= 1'b0;
            rvalid_q  <= 1'b0;
            inflight  <= 1'b0;
            buf_cnt   <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
        end else begin
            rbin      <= rbin_next;
            rptr_q    <= rgray_next;
            // Full gray equality: a pointer one lap behind differs in the MSB and is not empty.
            empty_int <= (rgray_next == wq);
            rlevel_q  <= level_next;
            ralmost_q <= (level_next <= bus.aempty_thr);
            rerr_q    <= bus.rinc & rempty_int;
            rvalid_q  <= (FWFT == 0) && pop_int;
            inflight  <= inflight_next;
            buf_cnt   <= occ_after[1:0];
            if (inflight) begin
                if (pop_out) begin
                    if (buf_cnt == 2'd2) begin
                        buf0 <= buf1;
                        buf1 <= bus.mem_rdata;
                    end else begin
                        buf0 <= bus.mem_rdata;
                    end
                end else if (buf_cnt == 2'd0) begin
                    buf0 <= bus.mem_rdata;
                end else begin
                    buf1 <= bus.mem_rdata;
                end
            end else if (pop_out) begin
                buf0 <= buf1;
            end
        end
    end

    assign bus.raddr         = rbin[ADDSIZE-1:0];
    assign bus.ren           = pop_int;
    assign bus.rdata         = (FWFT != 0) ? buf0 : bus.mem_rdata;
    assign bus.rvalid        = (FWFT != 0) ? (buf_cnt != 2'd0) : rvalid_q;
    assign bus.rempty        = rempty_int;
    assign bus.ralmost_empty = ralmost_q;
    assign bus.rlevel        = rlevel_q;
    assign bus.rptr          = rptr_q;
    assign bus.rerr          = rerr_q;

endmodule
